// File: rtl/usb_tx_crc16.sv
// rtl/usb_tx_crc16.sv - USB transmit framer: payload pass-through, CRC16 append, MAX_LEN truncation.
// Optional USB_TX_CRC_STATS_EN adds pkt_count / trunc_count outputs.
module usb_tx_crc16 #(
    parameter int MAX_LEN = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        busy,
    output logic        pkt_done,
    output logic        err_len
`ifdef USB_TX_CRC_STATS_EN
    ,
    output logic [15:0] pkt_count,
    output logic [7:0]  trunc_count
`endif
);

    localparam int CW = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC1 = 2'd2,
        CRC2 = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     crc_q, crc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pkt_done_q, pkt_done_d;
    logic            err_len_q, err_len_d;
    logic            at_max;

    // Whole byte folded into the reflected CRC in one cycle, LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    assign at_max = (cnt_q == CW'(MAX_LEN - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            crc_q      <= 16'hFFFF;
            cnt_q      <= '0;
            pkt_done_q <= 1'b0;
            err_len_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            cnt_q      <= cnt_d;
            pkt_done_q <= pkt_done_d;
            err_len_q  <= err_len_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        crc_d      = crc_q;
        cnt_d      = cnt_q;
        err_len_d  = err_len_q;
        pkt_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d   = DATA;
                    crc_d     = 16'hFFFF;
                    cnt_d     = '0;
                    err_len_d = 1'b0;
                end
            end
            DATA: begin
                if (in_valid && tx_ready) begin
                    crc_d = crc16_byte(crc_q, in_data);
                    cnt_d = cnt_q + CW'(1);
                    if (in_last || at_max) begin
                        state_d = CRC1;
                    end
                    if (at_max && !in_last) begin
                        err_len_d = 1'b1;
                    end
                end
            end
            CRC1: begin
                if (tx_ready) begin
                    state_d = CRC2;
                end
            end
            CRC2: begin
                if (tx_ready) begin
                    state_d    = IDLE;
                    pkt_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        in_ready = 1'b0;
        busy     = (state_q != IDLE);
        case (state_q)
            DATA: begin
                tx_valid = in_valid;
                tx_data  = in_data;
                in_ready = tx_ready;
            end
            CRC1: begin
                tx_valid = 1'b1;
                tx_data  = ~crc_q[7:0];
            end
            CRC2: begin
                tx_valid = 1'b1;
                tx_data  = ~crc_q[15:8];
            end
            default: begin
                tx_valid = 1'b0;
                tx_data  = 8'h00;
                in_ready = 1'b0;
            end
        endcase
    end

    assign pkt_done = pkt_done_q;
    assign err_len  = err_len_q;

`ifdef USB_TX_CRC_STATS_EN
    logic [15:0] pkt_count_q, pkt_count_d;
    logic [7:0]  trunc_count_q, trunc_count_d;

    always_comb begin
        pkt_count_d   = pkt_done_q ? pkt_count_q + 16'd1 : pkt_count_q;
        trunc_count_d = trunc_count_q;
        if (err_len_d && !err_len_q && (trunc_count_q != 8'hFF)) begin
            trunc_count_d = trunc_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_count_q   <= '0;
            trunc_count_q <= '0;
        end else begin
            pkt_count_q   <= pkt_count_d;
            trunc_count_q <= trunc_count_d;
        end
    end

    assign pkt_count   = pkt_count_q;
    assign trunc_count = trunc_count_q;
`endif

endmodule

// File: tb/tb_usb_tx_crc16.sv
// tb/tb_usb_tx_crc16.sv - randomized self-checking bench for usb_tx_crc16 (MAX_LEN=64 and MAX_LEN=4 instances).
module tb_usb_tx_crc16;

    typedef logic [7:0] byte_q[$];

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      in_valid, in_last, tx_ready;
    logic [1:0][7:0] in_data;
    logic [1:0]      in_ready, tx_valid, busy, pkt_done, err_len;
    logic [1:0][7:0] tx_data;
`ifdef USB_TX_CRC_STATS_EN
    logic [1:0][15:0] pkt_count;
    logic [1:0][7:0]  trunc_count;
`endif

    int n_vec = 0;
    int n_err = 0;
    bit exp_err[2];
    int exp_pkts[2];
    int exp_truncs[2];

    always #5 clk = ~clk;

    usb_tx_crc16 #(.MAX_LEN(64)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[0]), .in_data(in_data[0]), .in_last(in_last[0]), .in_ready(in_ready[0]),
        .tx_valid(tx_valid[0]), .tx_data(tx_data[0]), .tx_ready(tx_ready[0]),
        .busy(busy[0]), .pkt_done(pkt_done[0]), .err_len(err_len[0])
`ifdef USB_TX_CRC_STATS_EN
        , .pkt_count(pkt_count[0]), .trunc_count(trunc_count[0])
`endif
    );

    usb_tx_crc16 #(.MAX_LEN(4)) dut4 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[1]), .in_data(in_data[1]), .in_last(in_last[1]), .in_ready(in_ready[1]),
        .tx_valid(tx_valid[1]), .tx_data(tx_data[1]), .tx_ready(tx_ready[1]),
        .busy(busy[1]), .pkt_done(pkt_done[1]), .err_len(err_len[1])
`ifdef USB_TX_CRC_STATS_EN
        , .pkt_count(pkt_count[1]), .trunc_count(trunc_count[1])
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference CRC-16/USB: shift-register division, one payload bit at a time.
    function automatic logic [15:0] ref_crc(input byte_q data, input int n);
        logic [15:0] c;
        logic [7:0]  b;
        logic        fb;
        c = 16'hFFFF;
        for (int k = 0; k < n; k++) begin
            b = data[k];
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ b[j];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        end
        return c;
    endfunction

    task automatic check_reset_outputs(input int d);
        check("rst_tx_valid", tx_valid[d], 1'b0);
        check("rst_in_ready", in_ready[d], 1'b0);
        check("rst_busy",     busy[d],     1'b0);
        check("rst_pkt_done", pkt_done[d], 1'b0);
        check("rst_err_len",  err_len[d],  1'b0);
        check("rst_tx_data",  tx_data[d],  8'h00);
`ifdef USB_TX_CRC_STATS_EN
        check("rst_pkt_count",   pkt_count[d],   16'h0);
        check("rst_trunc_count", trunc_count[d], 8'h0);
`endif
    endtask

    // rmode: 0 ready held high, 1 ready pattern 1,0,0, 2 random ready and random source gaps.
    task automatic run_pkt(input int d, input byte_q pl, input bit use_last, input int rmode,
                           output byte_q got, output int done_cyc);
        int          maxlen, nexp, ph, sent, cyc;
        bit          trunc, iv, rd;
        logic [15:0] fin;
        logic        ev, er;
        logic [7:0]  ed;
        maxlen = (d == 1) ? 4 : 64;
        trunc  = !(use_last && pl.size() <= maxlen);
        nexp   = trunc ? maxlen : pl.size();
        fin    = ~ref_crc(pl, nexp);
        ph = 0; sent = 0; cyc = 0; done_cyc = -1;
        got = {};
        while (ph != 5 && cyc < 4000) begin
            @(negedge clk);
            if (ph == 0)                    iv = 1'b1;
            else if (ph == 1 && sent < nexp) iv = (rmode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            else                            iv = 1'b0;
            case (rmode)
                0:       rd = 1'b1;
                1:       rd = (cyc % 3 == 0);
                default: rd = $urandom_range(0, 1) == 1;
            endcase
            in_valid[d] = iv;
            in_data[d]  = (sent < pl.size()) ? pl[sent] : 8'h00;
            in_last[d]  = use_last && (sent == pl.size() - 1);
            tx_ready[d] = rd;
            #1;
            ev = 1'b0; er = 1'b0; ed = 8'h00;
            case (ph)
                1: begin ev = iv;   er = rd;   ed = in_data[d]; end
                2: begin ev = 1'b1; ed = fin[7:0];  end
                3: begin ev = 1'b1; ed = fin[15:8]; end
                default: ;
            endcase
            check("tx_valid", tx_valid[d], ev);
            check("in_ready", in_ready[d], er);
            if (ev) check("tx_data", tx_data[d], ed);
            check("busy",     busy[d],     (ph >= 1 && ph <= 3));
            check("pkt_done", pkt_done[d], ph == 4);
            check("err_len",  err_len[d],  exp_err[d]);
            if (tx_valid[d] && rd) got.push_back(tx_data[d]);
            case (ph)
                0: begin ph = 1; exp_err[d] = 1'b0; end
                1: if (iv && rd) begin
                       sent++;
                       if (sent == nexp) begin
                           ph = 2;
                           if (trunc) begin exp_err[d] = 1'b1; exp_truncs[d]++; end
                       end
                   end
                2: if (rd) ph = 3;
                3: if (rd) ph = 4;
                4: begin
`ifdef USB_TX_CRC_STATS_EN
                       check("pkt_count",   pkt_count[d],   exp_pkts[d]);
                       check("trunc_count", trunc_count[d], exp_truncs[d]);
`endif
                       exp_pkts[d]++;
                       done_cyc = cyc;
                       ph = 5;
                   end
                default: ;
            endcase
            cyc++;
        end
        check("pkt_timeout", ph, 5);
        in_valid[d] = 1'b0;
        in_last[d]  = 1'b0;
        tx_ready[d] = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            exp_err[i] = 1'b0; exp_pkts[i] = 0; exp_truncs[i] = 0;
        end
    endtask

    initial begin
        byte_q cv, pl, got;
        int    dc, len;
        bit    ul;
        cv = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        reset = 1'b1;
        in_valid = '0; in_last = '0; tx_ready = '0; in_data = '0;
        clear_model();
        repeat (3) @(negedge clk);
        check_reset_outputs(0);
        check_reset_outputs(1);
        reset = 1'b0;

        run_pkt(0, cv, 1'b1, 0, got, dc);
        check("cv_len", got.size(), 11);
        if (got.size() == 11) begin
            check("cv_crc_lo", got[9], 8'hC8);
            check("cv_crc_hi", got[10], 8'hB4);
        end
        check("cv_done_cycle", dc, 12);

        pl = {8'h00};
        run_pkt(0, pl, 1'b1, 0, got, dc);
        check("single_done_cycle", dc, 4);

        run_pkt(0, cv, 1'b1, 1, got, dc);
        check("bp_len", got.size(), 11);
        if (got.size() == 11) begin
            check("bp_crc_lo", got[9], 8'hC8);
            check("bp_crc_hi", got[10], 8'hB4);
        end

        pl = {8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
        run_pkt(1, pl, 1'b0, 0, got, dc);
        check("trunc_len", got.size(), 6);
        pl = {8'hA5, 8'h5A, 8'hFF};
        run_pkt(1, pl, 1'b1, 2, got, dc);
        pl = {8'h01, 8'h02, 8'h03, 8'h04};
        run_pkt(1, pl, 1'b1, 0, got, dc);
        @(negedge clk);
`ifdef USB_TX_CRC_STATS_EN
        check("stats_pkts",   pkt_count[1],   16'd3);
        check("stats_truncs", trunc_count[1], 8'd1);
`endif

        for (int p = 0; p < 24; p++) begin
            int d;
            d  = p % 2;
            ul = $urandom_range(0, 3) != 0;
            if (d == 0) len = ul ? $urandom_range(1, 64) : $urandom_range(64, 66);
            else        len = ul ? $urandom_range(1, 4)  : $urandom_range(4, 6);
            pl = {};
            for (int k = 0; k < len; k++) pl.push_back(8'($urandom_range(0, 255)));
            run_pkt(d, pl, ul, $urandom_range(0, 2), got, dc);
        end

        // Abort a packet after three accepted bytes.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid[0] = 1'b1;
            in_data[0]  = cv[(k == 0) ? 0 : k - 1];
            in_last[0]  = 1'b0;
            tx_ready[0] = 1'b1;
        end
        @(negedge clk);
        reset = 1'b1;
        in_valid[0] = 1'b0;
        tx_ready[0] = 1'b0;
        @(negedge clk);
        check_reset_outputs(0);
        reset = 1'b0;
        clear_model();
        run_pkt(0, cv, 1'b1, 0, got, dc);
        if (got.size() == 11) begin
            check("post_rst_crc_lo", got[9], 8'hC8);
            check("post_rst_crc_hi", got[10], 8'hB4);
        end else begin
            check("post_rst_len", got.size(), 11);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
